alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Sequencing and arbitration controller that shares the single combinational 32-bit ALU between two requesters: port 0 is the execute stage, port 1 is the address/branch helper. It accepts one operation at a time through a valid/ready handshake, drives the ALU from registered operands, captures F/C/Zero into a result register, and returns it to the requester that issued the operation. It sits between the requesters and the ALU instance; the ALU itself is unchanged.

## Interface
Parameters:
- SIZE, 32, operand/result width; must match the ALU's SIZE.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester n presents an operation.
- req0_ready / req1_ready  out  1  controller accepts requester n's operation this cycle.
- req0_op / req1_op  in  3  ALU opcode: AND=000, OR=001, XOR=010, NOR=011, ADD=100, SUB=101, SLT=110, SLL=111.
- req0_a, req0_b / req1_a, req1_b  in  SIZE  operands.
- rsp0_valid / rsp1_valid  out  1  result for requester n is available.
- rsp0_ready / rsp1_ready  in  1  requester n takes its result.
- rsp_f  out  SIZE  result word, shared by both response ports.
- rsp_c  out  1  carry/borrow flag, shared.
- rsp_zero  out  1  zero flag, shared.
- alu_op  out  3  to ALU OP.
- alu_a, alu_b  out  SIZE  to ALU A/B.
- alu_f  in  SIZE  from ALU F.
- alu_c, alu_zero  in  1  from ALU C and Zero.

## Operation
- States:
  - IDLE: waiting for a request.
  - EXEC: ALU inputs held stable.
  - RESP: result held for the owner.
- IDLE:
  - req_ready is high for at most one port. The granted port is chosen by the arbiter from req0_valid, req1_valid, and the priority pointer `prio`.
  - Only one valid: that port wins.
  - Both valid: port `prio` wins.
  - Neither valid: both readies are low.
  - On handshake (valid & ready): latch op/a/b into operand registers, record `owner`, set `prio` to the other port, go to EXEC.
- EXEC (exactly one cycle):
  - alu_op/alu_a/alu_b come from the operand registers.
  - At the clock edge, alu_f/alu_c/alu_zero are captured into rsp_f/rsp_c/rsp_zero; go to RESP.
- RESP:
  - rsp<owner>_valid is high; the other rsp_valid stays low.
  - Result registers are frozen.
  - On rsp<owner>_ready, go to IDLE; the rsp_ready of the non-owner is ignored.
- Outside EXEC, alu_* keep the last operand register contents. No new operand is latched outside IDLE.
- The controller does not interpret flags; C and Zero are passed through exactly as the ALU produces them.

## Timing
- Handshake in cycle N, rsp_valid high from cycle N+2. Minimum occupancy is 3 cycles per operation (IDLE, EXEC, RESP with same-cycle rsp_ready).
- Back-to-back: the cycle after RESP handshake is IDLE. A new grant can occur there, so the peak rate is one operation per 3 cycles.
- req_ready is combinational from state, valids and `prio`. A requester must hold valid/op/a/b stable until its ready is seen.
- rsp_valid, rsp_f, rsp_c and rsp_zero are registered outputs; there is no combinational path from alu_* to rsp_*.
- Reset values:
  - state=IDLE, prio=0, owner=0.
  - operand registers=0, so alu_op=000 (AND), alu_a=0, alu_b=0.
  - rsp_f=0, rsp_c=0, rsp_zero=0.
  - rsp0_valid=0, rsp1_valid=0.
  - req0_ready and req1_ready are low during the reset cycle.
- Reset mid-operation (in EXEC or RESP) discards the operation. No response is ever issued for it, and `prio` returns to 0.
- Simultaneous events:
  - A requester raising valid while another operation is in flight sees ready low until IDLE.
  - Both valid in IDLE: only the `prio` port's ready goes high.
  - A losing requester is guaranteed a grant at the next IDLE it is still valid in, so starvation is impossible.
- rsp_ready asserted while rsp_valid is low has no effect.

## Structure
- Shared package (alu_pkg): ALU opcode constants (ALU_AND..ALU_SLL, 3 bits) and the state encoding (ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2). The ALU and this controller both use the package.
- Sub-module alu_rr_arb2: purely combinational 2-way round-robin grant.
  - Inputs: req[1:0], prio, en.
  - Output: gnt[1:0] (one-hot or zero).
  - The controller holds the `prio` register and the FSM.
- The ALU is instantiated by the parent, not inside this block; the controller drives its ports only.

## Test plan
- Single ADD on port 0: a=32'h0000_0005, b=32'h0000_0003, rsp0_ready tied high.
  - Required: rsp0_valid in cycle N+2 with rsp_f=8, rsp_c=0, rsp_zero=0.
  - rsp1_valid stays 0 throughout.
- Contention: both valid in the same IDLE cycle after reset.
  - Port 0: SUB with a=7, b=7. Port 1: OR with a=1, b=2.
  - Required: port 0 is granted first, with rsp_f=0 and rsp_zero=1.
  - Port 1 is then granted at the next IDLE and returns rsp_f=3.
- Response backpressure: issue an op on port 1 and hold rsp1_ready low for 5 cycles.
  - Required: rsp1_valid stays high and rsp_f is unchanged.
  - req0_ready stays low throughout.
  - The op completes in the cycle rsp1_ready rises.
- Fairness: keep both ports continuously valid for 6 operations.
  - Required: grants alternate 0,1,0,1,0,1 and each op occupies exactly 3 cycles.
- Reset mid-operation: assert rst in EXEC, and separately in RESP.
  - Required: in both cases, next cycle state=IDLE and both rsp_valid are 0, with no response for the dropped op.
  - The next request on port 1 alone is granted immediately.
- SLL/SLT pass-through: SLL with a=4, b=32'h1, then SLT with a=2, b=9.
  - Required: rsp_f=32'h10 for the SLL, then rsp_f=1 for the SLT.
  - rsp_zero=0 for both.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants and the sharing controller's state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b011;
    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_SLL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Requester-side bundle of the ALU sharing controller: two request ports, two response ports, shared result.
interface alu_share_ctrl_if #(parameter int SIZE = 32);

    logic            req0_valid;
    logic            req0_ready;
    logic [2:0]      req0_op;
    logic [SIZE-1:0] req0_a;
    logic [SIZE-1:0] req0_b;
    logic            req1_valid;
    logic            req1_ready;
    logic [2:0]      req1_op;
    logic [SIZE-1:0] req1_a;
    logic [SIZE-1:0] req1_b;
    logic            rsp0_valid;
    logic            rsp0_ready;
    logic            rsp1_valid;
    logic            rsp1_ready;
    logic [SIZE-1:0] rsp_f;
    logic            rsp_c;
    logic            rsp_zero;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_f, rsp_c, rsp_zero
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_f, rsp_c, rsp_zero
    );

endinterface

// File: rtl/alu_share_ctrl_arb2.sv
// Two-way round-robin grant, purely combinational; prio names the port that wins a tie.
module alu_rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = prio ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters; one op in flight, response 2 cycles after grant,
// held (frozen) until the owner takes it; requests see ready low while an op is in flight.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    alu_share_ctrl_if.slave bus,
    output logic [2:0]      alu_op,
    output logic [SIZE-1:0] alu_a,
    output logic [SIZE-1:0] alu_b,
    input  logic [SIZE-1:0] alu_f,
    input  logic            alu_c,
    input  logic            alu_zero
);

    state_t          state;
    state_t          state_nxt;
    logic            prio;
    logic            owner;
    logic [2:0]      op_q;
    logic [SIZE-1:0] a_q;
    logic [SIZE-1:0] b_q;
    logic [SIZE-1:0] f_q;
    logic            c_q;
    logic            z_q;
    logic [1:0]      rsp_vld_q;
    logic [1:0]      gnt;
    logic            arb_en;
    logic            accept;
    logic            rsp_done;

    // Ready is masked during reset so nothing is accepted in the reset cycle.
    assign arb_en = (state == ST_IDLE) && !rst;

    alu_rr_arb2 u_arb (
        .req  ({bus.req1_valid, bus.req0_valid}),
        .prio (prio),
        .en   (arb_en),
        .gnt  (gnt)
    );

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];
    assign accept         = |gnt;
    assign rsp_done       = owner ? bus.rsp1_ready : bus.rsp0_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (rsp_done) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            prio      <= 1'b0;
            owner     <= 1'b0;
            op_q      <= ALU_AND;
            a_q       <= '0;
            b_q       <= '0;
            f_q       <= '0;
            c_q       <= 1'b0;
            z_q       <= 1'b0;
            rsp_vld_q <= 2'b00;
        end else begin
            state     <= state_nxt;
            // owner is already settled by the time RESP can be entered
            rsp_vld_q <= {owner, ~owner} & {2{state_nxt == ST_RESP}};
            if (accept) begin
                owner <= gnt[1];
                prio  <= gnt[0];
                op_q  <= gnt[1] ? bus.req1_op : bus.req0_op;
                a_q   <= gnt[1] ? bus.req1_a  : bus.req0_a;
                b_q   <= gnt[1] ? bus.req1_b  : bus.req0_b;
            end
            if (state == ST_EXEC) begin
                f_q <= alu_f;
                c_q <= alu_c;
                z_q <= alu_zero;
            end
        end
    end

    assign alu_op = op_q;
    assign alu_a  = a_q;
    assign alu_b  = b_q;

    assign bus.rsp0_valid = rsp_vld_q[0];
    assign bus.rsp1_valid = rsp_vld_q[1];
    assign bus.rsp_f      = f_q;
    assign bus.rsp_c      = c_q;
    assign bus.rsp_zero   = z_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: vector table, hand-written corner sequences, and a randomized scoreboard run.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_f;
    logic        alu_c;
    logic        alu_zero;
    logic [33:0] alu_res;

    int total = 0;
    int bad   = 0;

    logic        cur_v  [2];
    logic [2:0]  cur_op [2];
    logic [31:0] cur_a  [2];
    logic [31:0] cur_b  [2];

    alu_share_ctrl_if #(.SIZE(32)) bus ();

    alu_share_ctrl #(.SIZE(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .alu_op   (alu_op),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_f    (alu_f),
        .alu_c    (alu_c),
        .alu_zero (alu_zero)
    );

    // Returns {c, zero, f}; carry is add carry-out, borrow for SUB, 0 otherwise.
    function automatic logic [33:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] f;
        logic        c;
        c = 1'b0;
        f = '0;
        s = '0;
        case (op)
            3'd0: f = a & b;
            3'd1: f = a | b;
            3'd2: f = a ^ b;
            3'd3: f = ~(a | b);
            3'd4: begin s = {1'b0, a} + {1'b0, b}; f = s[31:0]; c = s[32]; end
            3'd5: begin f = a - b; c = (a < b); end
            3'd6: f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: f = b << a[4:0];
        endcase
        return {c, (f == 32'd0), f};
    endfunction

    always_comb alu_res = ref_alu(alu_op, alu_a, alu_b);
    assign alu_c    = alu_res[33];
    assign alu_zero = alu_res[32];
    assign alu_f    = alu_res[31:0];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(input int p, input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        cur_v[p] = v; cur_op[p] = op; cur_a[p] = a; cur_b[p] = b;
        if (p == 1) begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    task automatic set_rrdy(input int p, input logic v);
        if (p == 1) bus.rsp1_ready = v;
        else        bus.rsp0_ready = v;
    endtask

    function automatic logic req_rdy(input int p);
        return (p == 1) ? bus.req1_ready : bus.req0_ready;
    endfunction

    function automatic logic rsp_rdy(input int p);
        return (p == 1) ? bus.rsp1_ready : bus.rsp0_ready;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One complete operation on port p; the response is held back for `hold` cycles.
    task automatic do_op(input int p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input int maxw, input logic [31:0] ef, input logic ec, input logic ez);
        int k;
        logic [1:0] vpat;
        vpat = (p == 1) ? 2'b10 : 2'b01;
        @(posedge clk); #1;
        set_req(p, 1'b1, op, a, b);
        set_rrdy(p, hold == 0);
        k = 0;
        @(negedge clk);
        while (!req_rdy(p) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("grant_wait", (k <= maxw), 1);
        chk("grant_other_low", req_rdy(1 - p), 0);
        @(posedge clk); #1;
        set_req(p, 1'b0, op, a, b);
        @(negedge clk);
        chk("exec_rsp_low", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        chk("exec_alu_op", alu_op, op);
        chk("exec_alu_a", alu_a, a);
        chk("exec_alu_b", alu_b, b);
        @(negedge clk);
        chk("rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, vpat);
        chk("rsp_f", bus.rsp_f, ef);
        chk("rsp_flags", {bus.rsp_c, bus.rsp_zero}, {ec, ez});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            set_req(1 - p, 1'b1, ALU_AND, 32'd0, 32'd0);
            if (h == hold - 1) set_rrdy(p, 1'b1);
            @(negedge clk);
            chk("hold_valid", {bus.rsp1_valid, bus.rsp0_valid}, vpat);
            chk("hold_f", bus.rsp_f, ef);
            chk("hold_other_ready", req_rdy(1 - p), 0);
        end
        @(posedge clk); #1;
        set_req(1 - p, 1'b0, ALU_AND, 32'd0, 32'd0);
        @(negedge clk);
        chk("done_rsp_low", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        set_rrdy(p, 1'b0);
    endtask

    typedef struct {
        int          port;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          hold;
        logic [31:0] f;
        logic        c;
        logic        z;
    } vec_t;

    typedef struct {
        int          port;
        logic [33:0] r;
    } exp_t;

    initial begin
        vec_t  vt[10];
        exp_t  expq[$];
        exp_t  e;
        logic  hs[2];
        int    grants;
        int    resps;
        int    last_cyc;
        int    last_w;
        int    w;
        int    seen;

        vt[0] = '{0, ALU_ADD, 32'h0000_0005, 32'h0000_0003, 0, 32'h0000_0008, 1'b0, 1'b0};
        vt[1] = '{1, ALU_OR,  32'h0000_0001, 32'h0000_0002, 5, 32'h0000_0003, 1'b0, 1'b0};
        vt[2] = '{0, ALU_SLL, 32'h0000_0004, 32'h0000_0001, 0, 32'h0000_0010, 1'b0, 1'b0};
        vt[3] = '{1, ALU_SLT, 32'h0000_0002, 32'h0000_0009, 0, 32'h0000_0001, 1'b0, 1'b0};
        vt[4] = '{0, ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 0, 32'h0000_0000, 1'b1, 1'b1};
        vt[5] = '{1, ALU_SUB, 32'h0000_0003, 32'h0000_0005, 2, 32'hFFFF_FFFE, 1'b1, 1'b0};
        vt[6] = '{0, ALU_NOR, 32'h0000_0000, 32'h0000_0000, 0, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vt[7] = '{1, ALU_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000, 0, 32'h5A5A_A5A5, 1'b0, 1'b0};
        vt[8] = '{0, ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 32'h00F0_00F0, 1'b0, 1'b0};
        vt[9] = '{0, ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 0, 32'h0000_0001, 1'b0, 1'b0};

        rst = 1'b1;
        set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd1);
        set_req(1, 1'b1, ALU_ADD, 32'd2, 32'd2);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        hs[0] = 1'b0;
        hs[1] = 1'b0;

        // Reset state, with both requesters valid during reset
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        chk("rst_req_ready", {bus.req1_ready, bus.req0_ready}, 0);
        chk("rst_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        chk("rst_rsp_word", {bus.rsp_f, bus.rsp_c, bus.rsp_zero}, 0);
        chk("rst_alu", {alu_op, alu_a, alu_b}, 0);
        set_req(0, 1'b0, ALU_AND, 32'd0, 32'd0);
        set_req(1, 1'b0, ALU_AND, 32'd0, 32'd0);
        set_rrdy(0, 1'b0);
        set_rrdy(1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Contention straight after reset: port 0 first, port 1 at the next IDLE
        @(posedge clk); #1;
        set_req(0, 1'b1, ALU_SUB, 32'd7, 32'd7);
        set_req(1, 1'b1, ALU_OR, 32'd1, 32'd2);
        set_rrdy(0, 1'b1);
        set_rrdy(1, 1'b1);
        @(negedge clk);
        chk("cont_ready", {bus.req1_ready, bus.req0_ready}, 2'b01);
        @(posedge clk); #1;
        set_req(0, 1'b0, ALU_SUB, 32'd7, 32'd7);
        @(negedge clk);
        chk("cont_exec_ready", {bus.req1_ready, bus.req0_ready}, 0);
        @(negedge clk);
        chk("cont_rsp0_valid", {bus.rsp1_valid, bus.rsp0_valid}, 2'b01);
        chk("cont_rsp0_f", bus.rsp_f, 0);
        chk("cont_rsp0_zero", bus.rsp_zero, 1);
        @(negedge clk);
        chk("cont_p1_grant", {bus.req1_ready, bus.req0_ready}, 2'b10);
        @(posedge clk); #1;
        set_req(1, 1'b0, ALU_OR, 32'd1, 32'd2);
        @(negedge clk);
        @(negedge clk);
        chk("cont_rsp1_valid", {bus.rsp1_valid, bus.rsp0_valid}, 2'b10);
        chk("cont_rsp1_f", bus.rsp_f, 32'd3);
        @(posedge clk); #1;
        set_rrdy(0, 1'b0);
        set_rrdy(1, 1'b0);

        for (int i = 0; i < 10; i++)
            do_op(vt[i].port, vt[i].op, vt[i].a, vt[i].b, vt[i].hold, 1, vt[i].f, vt[i].c, vt[i].z);

        // Fairness: both ports continuously valid for six operations
        do_reset();
        @(posedge clk); #1;
        set_req(0, 1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom);
        set_req(1, 1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom);
        set_rrdy(0, 1'b1);
        set_rrdy(1, 1'b1);
        grants = 0; resps = 0; last_cyc = 0;
        for (int cyc = 0; cyc < 60 && resps < 6; cyc++) begin
            @(negedge clk);
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                e = expq.pop_front();
                chk("fair_rsp_port", {bus.rsp1_valid, bus.rsp0_valid}, (e.port == 1) ? 2'b10 : 2'b01);
                chk("fair_rsp_val", {bus.rsp_c, bus.rsp_zero, bus.rsp_f}, e.r);
                resps++;
            end
            hs[0] = bus.req0_ready;
            hs[1] = bus.req1_ready;
            if ((hs[0] || hs[1]) && grants < 6) begin
                w = hs[1] ? 1 : 0;
                chk("fair_order", w, grants % 2);
                if (grants > 0) chk("fair_gap", cyc - last_cyc, 3);
                last_cyc = cyc;
                expq.push_back('{w, ref_alu(cur_op[w], cur_a[w], cur_b[w])});
                grants++;
            end
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++)
                if (grants >= 6) set_req(p, 1'b0, ALU_AND, 32'd0, 32'd0);
                else if (hs[p]) set_req(p, 1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom);
        end
        chk("fair_resp_count", resps, 6);
        set_rrdy(0, 1'b0);
        set_rrdy(1, 1'b0);

        // Reset during EXEC, then a lone port 1 request is granted at once
        @(posedge clk); #1;
        set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd2);
        set_rrdy(0, 1'b1);
        @(negedge clk);
        chk("rx_grant", bus.req0_ready, 1);
        @(posedge clk); #1;
        set_req(0, 1'b0, ALU_ADD, 32'd1, 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rx_rsp_low", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.rsp0_valid || bus.rsp1_valid) seen++;
        end
        chk("rx_no_late_rsp", seen, 0);
        set_rrdy(0, 1'b0);
        do_op(1, ALU_XOR, 32'h0000_00FF, 32'h0000_0F0F, 0, 0, 32'h0000_0FF0, 1'b0, 1'b0);

        // Reset during RESP on a port 0 op; prio must come back to port 0
        @(posedge clk); #1;
        set_req(0, 1'b1, ALU_SUB, 32'd9, 32'd4);
        @(negedge clk);
        chk("rr_grant", bus.req0_ready, 1);
        @(posedge clk); #1;
        set_req(0, 1'b0, ALU_SUB, 32'd9, 32'd4);
        @(negedge clk);
        @(negedge clk);
        chk("rr_in_resp", {bus.rsp1_valid, bus.rsp0_valid}, 2'b01);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rr_rsp_low", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        chk("rr_rsp_f", bus.rsp_f, 0);
        @(posedge clk); #1;
        set_req(0, 1'b1, ALU_AND, 32'd3, 32'd1);
        set_req(1, 1'b1, ALU_AND, 32'd3, 32'd1);
        set_rrdy(0, 1'b1);
        @(negedge clk);
        chk("rr_prio_reset", {bus.req1_ready, bus.req0_ready}, 2'b01);
        @(posedge clk); #1;
        set_req(0, 1'b0, ALU_AND, 32'd0, 32'd0);
        set_req(1, 1'b0, ALU_AND, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) @(posedge clk);
        #1;
        set_rrdy(0, 1'b0);

        // Randomized traffic against the scoreboard
        do_reset();
        last_w = 1;
        hs[0] = 1'b0;
        hs[1] = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (hs[p]) set_req(p, 1'b0, cur_op[p], cur_a[p], cur_b[p]);
                if (!cur_v[p] && cyc < 270 && $urandom_range(0, 2) == 0)
                    set_req(p, 1'b1, 3'($urandom_range(0, 7)),
                            ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3)),
                            ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3)));
                set_rrdy(p, (cyc >= 270) || ($urandom_range(0, 1) == 1));
            end
            @(negedge clk);
            hs[0] = bus.req0_ready & cur_v[0];
            hs[1] = bus.req1_ready & cur_v[1];
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                chk("rnd_rsp_onehot", $countones({bus.rsp1_valid, bus.rsp0_valid}), 1);
                w = bus.rsp1_valid ? 1 : 0;
                if (rsp_rdy(w)) begin
                    chk("rnd_rsp_pending", expq.size(), 1);
                    if (expq.size() > 0) begin
                        e = expq.pop_front();
                        chk("rnd_rsp_port", w, e.port);
                        chk("rnd_rsp_val", {bus.rsp_c, bus.rsp_zero, bus.rsp_f}, e.r);
                    end
                end
            end
            if (bus.req0_ready || bus.req1_ready) begin
                chk("rnd_gnt_onehot", $countones({bus.req1_ready, bus.req0_ready}), 1);
                w = bus.req1_ready ? 1 : 0;
                if (cur_v[0] && cur_v[1]) chk("rnd_fair", w, 1 - last_w);
                last_w = w;
                chk("rnd_one_inflight", expq.size(), 0);
                expq.push_back('{w, ref_alu(cur_op[w], cur_a[w], cur_b[w])});
            end
        end
        chk("rnd_drained", expq.size(), 0);
        chk("rnd_no_pending", {cur_v[1], cur_v[0]}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
